seven_segment_counter_mux: RTL and testbench
============================================

# seven_segment_counter_mux

Parametrised multi-digit BCD seconds counter with a time-multiplexed seven-segment driver. A programmable prescaler produces a count tick. A NUM_DIGITS-wide cascaded BCD counter counts up or down on each tick. A scan engine drives one digit at a time through a shared segment bus with a one-hot digit select. It is the multi-digit, up/down, clear/enable-capable generation of the single-digit seconds display and sits between the register/control interface and the board's LED pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of BCD digits (1..8).
- CNT_W, 24: prescaler and compare width.
- DEFAULT_COMPARE, 16_000_000: compare value loaded at reset.
- SCAN_DIV, 1000: clk cycles per scanned digit (≥1).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- compare_in  in  CNT_W  new prescaler period.
- update_compare  in  1  load compare_in; restarts prescaler and clears digits.
- clear  in  1  synchronous: zero prescaler and all digits; compare retained.
- enable  in  1  1 = prescaler runs; 0 = hold (scan keeps running).
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick.
- led_out  out  7  segments {g,f,e,d,c,b,a}, active-high, for the selected digit.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; bit 0 = least-significant digit.
- tick  out  1  one-cycle pulse, one per count step.
- carry_out  out  1  one-cycle pulse when the whole counter wraps.

## Operation
- Priority per cycle: reset_n low > update_compare > clear > enable.
- Reset values: prescaler 0, compare DEFAULT_COMPARE, all digits 0, scan index 0, scan divider 0, led_out 7'b0111111 (digit 0 shows "0"), digit_sel one-hot bit 0, tick 0, carry_out 0.
- Prescaler: when enable=1 and prescaler == eff_compare−1, it returns to 0 and a step occurs; otherwise it increments. eff_compare = max(compare,1), so compare 0 or 1 gives a step every enabled cycle.
- Step up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. If all digits are 9, all become 0 and carry_out pulses.
- Step down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. If all digits are 0, all become 9 and carry_out pulses.
- Digits hold only values 0..9. The decoder blanks any other code (7'b0000000), which is unreachable in normal operation.
- update_compare and clear suppress any step in that cycle; no tick or carry_out is generated.
- Scan: the divider counts 0..SCAN_DIV−1. On wrap, the scan index advances modulo NUM_DIGITS. The scan runs regardless of enable, clear and update_compare.
- Segment encoding: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111.

## Timing
- Every output is registered. There are no combinational input-to-output paths.
- Step occurs at edge E. Digit registers hold the new value after E, and tick/carry_out are high for the cycle following E.
- led_out and digit_sel update at the same edge, so they are always mutually consistent. Both are one cycle behind the scan index and digit registers.
- A displayed digit change appears at most SCAN_DIV·NUM_DIGITS+1 cycles after the step.
- update_compare at edge E: the prescaler is 0 after E, and the first step occurs at edge E+eff_compare.
- reset_n assertion clears every output immediately (asynchronously). Deassertion is synchronised externally; the block takes no action on release.

## Structure
- Package seven_segment_pkg:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - BCD digit width (4).
  - Default parameter values.
- Sub-module seg7_decode: combinational 4-bit to 7-segment decoder, blank on 10..15, instantiated once on the scan mux output.
- The top level contains:
  - prescaler
  - generate-loop BCD cascade
  - scan divider/index
  - output registers

## Test plan
NUM_DIGITS=2, SCAN_DIV=2, compare loaded as 3 unless noted.
- Reset: reset_n=0 mid-run → outputs immediately led_out=0111111, digit_sel=01, tick=0, carry_out=0. After release with enable=1, the first tick pulses DEFAULT_COMPARE cycles later (check with DEFAULT_COMPARE=5).
- Up count: enable=1, up_down=1 for 300 cycles → tick every 3 cycles. Digits step 00→…→99→00, with carry_out a single pulse at the 99→00 wrap. The scanned "12" shows led_out 0000110 with digit_sel=10 and 1011011 with digit_sel=01.
- Down count: start 00 with up_down=0 → next step shows 99 with a carry_out pulse, then 98. Toggling up_down mid-run reverses direction on the next tick.
- Compare edge: load compare 0, then 1 → a tick every enabled cycle in both cases. Load 3 mid-count → prescaler and digits restart at 0, and the first tick comes 3 cycles later.
- Simultaneous events: update_compare and clear in the step cycle → no tick, digits 00, compare updated. enable=0 → digits frozen while digit_sel keeps rotating 01,10,01.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared constants for the multiplexed BCD seven-segment counter.
package seven_segment_pkg;
    localparam int BCD_W = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_CNT_W = 24;
    localparam int DEF_COMPARE = 16_000_000;
    localparam int DEF_SCAN_DIV = 1000;
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111100;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seven_segment_counter_mux_seg7_decode.sv
// seg7_decode: BCD digit to active-high {g,f,e,d,c,b,a} segments, blank on 10..15.
module seg7_decode
    import seven_segment_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    always_comb begin
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_segment_counter_mux.sv
// seven_segment_counter_mux: prescaled up/down BCD counter with a time-multiplexed
// seven-segment scan driver.
module seven_segment_counter_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEFAULT_COMPARE = DEF_COMPARE,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CNT_W-1:0]      compare_in,
    input  logic                  update_compare,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  up_down,
    output logic [6:0]            led_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  tick,
    output logic                  carry_out
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    logic [CNT_W-1:0] prescaler, compare, eff_compare;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] digits, nxt;
    logic [NUM_DIGITS:0] chain;
    logic [SW-1:0] scan_div;
    logic [IW-1:0] scan_idx;
    logic step, scan_wrap;
    logic [6:0] seg;
    assign eff_compare = (compare == '0) ? CNT_W'(1) : compare;
    assign step = enable && !update_compare && !clear && (prescaler == eff_compare - CNT_W'(1));
    assign scan_wrap = (scan_div == SW'(SCAN_DIV - 1));
    // chain[k] is high when digit k must roll this cycle; chain[NUM_DIGITS] is the whole-counter wrap
    always_comb begin
        chain[0] = step;
        for (int k = 0; k < NUM_DIGITS; k++)
            chain[k+1] = chain[k] && (digits[k] == (up_down ? BCD_W'(9) : BCD_W'(0)));
    end
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign nxt[i] = !chain[i] ? digits[i] :
                        up_down ? (digits[i] == BCD_W'(9) ? '0 : digits[i] + 1'b1) :
                                  (digits[i] == '0 ? BCD_W'(9) : digits[i] - 1'b1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            compare <= CNT_W'(DEFAULT_COMPARE);
            digits <= '0;
            tick <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            tick <= step;
            carry_out <= chain[NUM_DIGITS];
            if (update_compare) begin
                compare <= compare_in;
                prescaler <= '0;
                digits <= '0;
            end else if (clear) begin
                prescaler <= '0;
                digits <= '0;
            end else begin
                digits <= nxt;
                if (enable) prescaler <= step ? '0 : prescaler + 1'b1;
            end
        end
    end
    seg7_decode u_dec (.bcd(digits[scan_idx]), .seg(seg));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_div <= '0;
            scan_idx <= '0;
            led_out <= SEG_0;
            digit_sel <= NUM_DIGITS'(1);
        end else begin
            scan_div <= scan_wrap ? '0 : scan_div + 1'b1;
            if (scan_wrap) scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            led_out <= seg;
            digit_sel <= NUM_DIGITS'(1) << scan_idx;
        end
    end
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// tb_seven_segment_counter_mux: vector table, hand sequences and randomized run
// against an arithmetic model of the counter and scan.
module tb_seven_segment_counter_mux;
    localparam int ND = 2;
    localparam int CW = 8;
    localparam int SD = 2;
    logic clk = 0, reset_n = 0;
    logic [CW-1:0] compare_in = '0;
    logic update_compare = 0, clear = 0, enable = 0, up_down = 1;
    logic [6:0] led_out;
    logic [ND-1:0] digit_sel;
    logic tick, carry_out;
    int checks = 0, errors = 0;
    int m_val, m_pre, m_cmp, m_sidx, m_sdiv;
    int e_led, e_sel, e_tick, e_carry;
    int segtab[10] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66, 'h6d, 'h7c, 'h07, 'h7f, 'h67};

    typedef struct {
        bit u, c, e, ud;
        int ci;
        bit tk, cy;
    } vec_t;
    vec_t tbl[$];

    seven_segment_counter_mux #(.NUM_DIGITS(ND), .CNT_W(CW), .DEFAULT_COMPARE(5), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset_n(reset_n), .compare_in(compare_in), .update_compare(update_compare),
        .clear(clear), .enable(enable), .up_down(up_down), .led_out(led_out),
        .digit_sel(digit_sel), .tick(tick), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_led"}, led_out, 'h3f);
        check({tag, "_sel"}, digit_sel, 1);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_carry"}, carry_out, 0);
    endtask

    task automatic model_reset();
        m_val = 0; m_pre = 0; m_cmp = 5; m_sidx = 0; m_sdiv = 0;
        e_led = segtab[0]; e_sel = 1; e_tick = 0; e_carry = 0;
    endtask

    task automatic cyc(input bit u, input bit c, input bit e, input bit ud, input int ci);
        int eff, top;
        update_compare = u; clear = c; enable = e; up_down = ud; compare_in = CW'(ci);
        @(posedge clk);
        top = 10 ** ND;
        eff = (m_cmp == 0) ? 1 : m_cmp;
        e_sel = 1 << m_sidx;
        e_led = segtab[(m_val / (10 ** m_sidx)) % 10];
        e_tick = 0; e_carry = 0;
        if (u) begin
            m_cmp = ci; m_pre = 0; m_val = 0;
        end else if (c) begin
            m_pre = 0; m_val = 0;
        end else if (e) begin
            if (m_pre == eff - 1) begin
                m_pre = 0; e_tick = 1;
                if (ud) begin
                    e_carry = (m_val == top - 1);
                    m_val = (m_val + 1) % top;
                end else begin
                    e_carry = (m_val == 0);
                    m_val = (m_val + top - 1) % top;
                end
            end else m_pre++;
        end
        if (m_sdiv == SD - 1) begin
            m_sdiv = 0; m_sidx = (m_sidx + 1) % ND;
        end else m_sdiv++;
        @(negedge clk);
        check("led", led_out, e_led);
        check("sel", digit_sel, e_sel);
        check("tick", tick, e_tick);
        check("carry", carry_out, e_carry);
    endtask

    task automatic first_tick_test(input string tag);
        int n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            cyc(0, 0, 1, 1, 0);
            if (tick) n = i;
        end
        check(tag, n, 5);
    endtask

    initial begin
        int ticks, carries;
        bit ud, seen_hi, seen_lo;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1;
        model_reset();
        first_tick_test("first_tick_cycles");

        tbl.push_back('{1,0,1,1,3,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,1,0}); tbl.push_back('{0,1,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,1,0}); tbl.push_back('{0,0,0,1,0,0,0});
        tbl.push_back('{0,0,0,1,0,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{1,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{0,0,1,1,0,1,0}); tbl.push_back('{1,0,1,1,1,0,0});
        tbl.push_back('{0,0,1,1,0,1,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{1,1,1,1,3,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{0,1,1,0,0,0,0}); tbl.push_back('{0,0,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,0,0,0}); tbl.push_back('{0,0,1,0,0,1,1});
        tbl.push_back('{0,0,1,0,0,0,0}); tbl.push_back('{0,0,1,0,0,0,0});
        tbl.push_back('{0,0,1,0,0,1,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,1,0});
        tbl.push_back('{0,0,1,1,0,0,0}); tbl.push_back('{0,0,1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0,1,1});
        foreach (tbl[i]) begin
            cyc(tbl[i].u, tbl[i].c, tbl[i].e, tbl[i].ud, tbl[i].ci);
            check($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
            check($sformatf("tbl%0d_carry", i), carry_out, tbl[i].cy);
        end

        cyc(0, 1, 1, 1, 0);
        for (int i = 0; i < 36; i++) cyc(0, 0, 1, 1, 0);
        seen_hi = 0; seen_lo = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (i >= 2) begin
                check("show12", led_out, digit_sel == 2'b10 ? 'h06 : 'h5b);
                if (digit_sel == 2'b10) seen_hi = 1;
                if (digit_sel == 2'b01) seen_lo = 1;
            end
        end
        check("frozen_scan_rotates", {seen_hi, seen_lo}, 3);

        cyc(0, 1, 1, 1, 0);
        ticks = 0; carries = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1, 1, 0);
            ticks += int'(tick);
            carries += int'(carry_out);
        end
        check("wrap_ticks", ticks, 100);
        check("wrap_carries", carries, 1);

        ud = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) ud = ~ud;
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 7) != 0, ud, $urandom_range(0, 4));
        end

        #2 reset_n = 0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset_n = 1;
        model_reset();
        first_tick_test("first_tick_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
